// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: controller state encoding, the event bundle
// produced by the priority decode, and the default sizing constants shared
// with clock_divider.
package stopwatch_pkg;

  // Default wrap point (4-digit display) and the count width that holds it.
  localparam int unsigned MAX_COUNT_DEF = 9999;
  localparam int unsigned CNT_W_DEF     = 14;

  // Divider terminal count for a 1 Hz enable from a 100 MHz clock.
  localparam int unsigned DIV_TERMINAL  = 99_999_999;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_e;

  // One cycle's worth of qualified events after priority resolution.
  typedef struct packed {
    logic clear;   // return to IDLE, wipe count, lap and wrap flag
    logic toggle;  // start_stop that survived clear
    logic lap;     // lap capture, only in RUN/PAUSE and not under clear
    logic tick;    // tick that actually advances the count
  } sw_evt_t;

endpackage

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear controller for the 1 Hz seconds counter.
// Ports:
//   clk_in         system clock
//   rst_n_in       synchronous active-low reset
//   tick_en_in     1 Hz single-cycle enable from the divider
//   start_stop_in  pulse: IDLE->RUN, RUN<->PAUSE
//   clear_in       pulse: back to IDLE with everything zeroed
//   lap_in         pulse: capture the current count
//   div_clear_out  pulse: restart the divider phase (start and clear)
//   run_out        high while in RUN
//   seconds_out    current count
//   lap_out        last captured count
//   lap_valid_out  pulse when lap_out updates
//   wrap_out       pulse on MAX_COUNT->0
//   wrapped_out    sticky wrap flag, cleared by clear or reset
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_COUNT = MAX_COUNT_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             tick_en_in,
  input  logic             start_stop_in,
  input  logic             clear_in,
  input  logic             lap_in,
  output logic             div_clear_out,
  output logic             run_out,
  output logic [CNT_W-1:0] seconds_out,
  output logic [CNT_W-1:0] lap_out,
  output logic             lap_valid_out,
  output logic             wrap_out,
  output logic             wrapped_out
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_COUNT);

  sw_state_e state;
  sw_evt_t   evt_c;
  logic      at_max_c;

  // Event-priority decode: clear > start_stop > lap; ticks only count in RUN.
  always_comb begin
    evt_c        = '0;
    evt_c.clear  = clear_in;
    evt_c.toggle = start_stop_in && !clear_in;
    evt_c.lap    = lap_in && !clear_in &&
                   ((state == ST_RUN) || (state == ST_PAUSE));
    evt_c.tick   = tick_en_in && !clear_in && (state == ST_RUN);
    at_max_c     = (seconds_out == MAX_VAL);
  end

  // State, counter, lap register and all registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state         <= ST_IDLE;
      div_clear_out <= 1'b0;
      run_out       <= 1'b0;
      seconds_out   <= '0;
      lap_out       <= '0;
      lap_valid_out <= 1'b0;
      wrap_out      <= 1'b0;
      wrapped_out   <= 1'b0;
    end else begin
      div_clear_out <= 1'b0;
      lap_valid_out <= 1'b0;
      wrap_out      <= 1'b0;

      if (evt_c.clear) begin
        state         <= ST_IDLE;
        run_out       <= 1'b0;
        seconds_out   <= '0;
        lap_out       <= '0;
        wrapped_out   <= 1'b0;
        div_clear_out <= 1'b1;
      end else begin
        // Increment is applied even when a stop coincides, so no tick is lost.
        if (evt_c.tick) begin
          if (at_max_c) begin
            seconds_out <= '0;
            wrap_out    <= 1'b1;
            wrapped_out <= 1'b1;
          end else begin
            seconds_out <= seconds_out + CNT_W'(1);
          end
        end

        // Lap takes the pre-increment value visible this cycle.
        if (evt_c.lap) begin
          lap_out       <= seconds_out;
          lap_valid_out <= 1'b1;
        end

        case (state)
          ST_IDLE: begin
            if (evt_c.toggle) begin
              state         <= ST_RUN;
              run_out       <= 1'b1;
              div_clear_out <= 1'b1;
            end
          end
          ST_RUN: begin
            if (evt_c.toggle) begin
              state   <= ST_PAUSE;
              run_out <= 1'b0;
            end
          end
          ST_PAUSE: begin
            // Resume keeps the divider phase running; no div_clear here.
            if (evt_c.toggle) begin
              state   <= ST_RUN;
              run_out <= 1'b1;
            end
          end
          default: begin
            state       <= ST_IDLE;
            run_out     <= 1'b0;
            seconds_out <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a directed vector table on the default-size
// instance, hand sequences for wrap corners, and random stimulus checked
// against a behavioural model on both a default and a MAX_COUNT=9 instance.
module tb_stopwatch_ctrl;

  localparam int unsigned CW = 14;

  logic clk_in = 1'b0;
  logic rst_n_in, tick_en_in, start_stop_in, clear_in, lap_in;

  logic          a_divclr, a_run, a_lapv, a_wrap, a_wrapped;
  logic [CW-1:0] a_secs, a_lap;
  logic          b_divclr, b_run, b_lapv, b_wrap, b_wrapped;
  logic [CW-1:0] b_secs, b_lap;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_in = ~clk_in;

  stopwatch_ctrl #(.MAX_COUNT(9999), .CNT_W(CW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .tick_en_in(tick_en_in),
    .start_stop_in(start_stop_in), .clear_in(clear_in), .lap_in(lap_in),
    .div_clear_out(a_divclr), .run_out(a_run), .seconds_out(a_secs),
    .lap_out(a_lap), .lap_valid_out(a_lapv), .wrap_out(a_wrap),
    .wrapped_out(a_wrapped)
  );

  stopwatch_ctrl #(.MAX_COUNT(9), .CNT_W(CW)) dut9 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .tick_en_in(tick_en_in),
    .start_stop_in(start_stop_in), .clear_in(clear_in), .lap_in(lap_in),
    .div_clear_out(b_divclr), .run_out(b_run), .seconds_out(b_secs),
    .lap_out(b_lap), .lap_valid_out(b_lapv), .wrap_out(b_wrap),
    .wrapped_out(b_wrapped)
  );

  // Behavioural model. mode: 0 stopped/idle, 1 counting, 2 paused.
  int m_mode[2], m_secs[2], m_lap[2];
  bit m_lapv[2], m_wrap[2], m_wrapped[2], m_divclr[2];

  task automatic model_step(input int k, input int maxc,
                            input bit r, input bit ss, input bit cl,
                            input bit lp, input bit tk);
    int old;
    m_divclr[k] = 0; m_lapv[k] = 0; m_wrap[k] = 0;
    if (!r) begin
      m_mode[k] = 0; m_secs[k] = 0; m_lap[k] = 0; m_wrapped[k] = 0;
      return;
    end
    if (cl) begin
      m_mode[k] = 0; m_secs[k] = 0; m_lap[k] = 0; m_wrapped[k] = 0;
      m_divclr[k] = 1;
      return;
    end
    old = m_secs[k];
    if (lp && m_mode[k] != 0) begin
      m_lap[k] = old; m_lapv[k] = 1;
    end
    if (tk && m_mode[k] == 1) begin
      if (old == maxc) begin
        m_secs[k] = 0; m_wrap[k] = 1; m_wrapped[k] = 1;
      end else begin
        m_secs[k] = old + 1;
      end
    end
    if (ss) begin
      if (m_mode[k] == 0) begin
        m_mode[k] = 1; m_divclr[k] = 1;
      end else if (m_mode[k] == 1) begin
        m_mode[k] = 2;
      end else begin
        m_mode[k] = 1;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m0.run",     int'(a_run),     int'(m_mode[0] == 1));
    chk("m0.secs",    int'(a_secs),    m_secs[0]);
    chk("m0.lap",     int'(a_lap),     m_lap[0]);
    chk("m0.lapv",    int'(a_lapv),    int'(m_lapv[0]));
    chk("m0.wrap",    int'(a_wrap),    int'(m_wrap[0]));
    chk("m0.wrapped", int'(a_wrapped), int'(m_wrapped[0]));
    chk("m0.divclr",  int'(a_divclr),  int'(m_divclr[0]));
    chk("m9.run",     int'(b_run),     int'(m_mode[1] == 1));
    chk("m9.secs",    int'(b_secs),    m_secs[1]);
    chk("m9.lap",     int'(b_lap),     m_lap[1]);
    chk("m9.lapv",    int'(b_lapv),    int'(m_lapv[1]));
    chk("m9.wrap",    int'(b_wrap),    int'(m_wrap[1]));
    chk("m9.wrapped", int'(b_wrapped), int'(m_wrapped[1]));
    chk("m9.divclr",  int'(b_divclr),  int'(m_divclr[1]));
  endtask

  // One clock: drive inputs, advance model on the edge, sample 1 ns later.
  task automatic cycle(input bit r, input bit ss, input bit cl,
                       input bit lp, input bit tk);
    rst_n_in = r; start_stop_in = ss; clear_in = cl; lap_in = lp;
    tick_en_in = tk;
    @(posedge clk_in);
    model_step(0, 9999, r, ss, cl, lp, tk);
    model_step(1, 9, r, ss, cl, lp, tk);
    #1;
    check_model();
  endtask

  typedef struct {
    bit rst_n, ss, clr, lap, tick;
    bit e_run; int e_secs; int e_lap;
    bit e_lapv, e_wrap, e_wrapped, e_divclr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit ss, input bit cl, input bit lp,
                     input bit tk, input bit run, input int secs,
                     input int lap, input bit lapv, input bit divclr);
    vec_t v;
    v.rst_n = r; v.ss = ss; v.clr = cl; v.lap = lp; v.tick = tk;
    v.e_run = run; v.e_secs = secs; v.e_lap = lap; v.e_lapv = lapv;
    v.e_wrap = 0; v.e_wrapped = 0; v.e_divclr = divclr;
    tbl.push_back(v);
  endtask

  initial begin
    rst_n_in = 0; start_stop_in = 0; clear_in = 0; lap_in = 0;
    tick_en_in = 0;

    // Directed vectors on the default instance (MAX_COUNT=9999).
    for (int i = 0; i < 3; i++) add(0,0,0,0,0, 0,0,0,0,0);
    add(1,0,0,0,0, 0,0,0,0,0);
    add(1,1,0,0,0, 1,0,0,0,1);                 // start: div_clear pulse
    for (int k = 1; k <= 5; k++) begin
      for (int j = 0; j < 9; j++) add(1,0,0,0,0, 1,k-1,0,0,0);
      add(1,0,0,0,1, 1,k,0,0,0);
    end
    add(1,0,1,0,0, 0,0,0,0,1);                 // clear
    add(1,1,0,0,0, 1,0,0,0,1);
    for (int k = 1; k <= 3; k++) add(1,0,0,0,1, 1,k,0,0,0);
    add(1,1,0,0,1, 0,4,0,0,0);                 // stop with tick: tick kept
    for (int k = 0; k < 3; k++) add(1,0,0,0,1, 0,4,0,0,0);
    add(1,1,0,0,0, 1,4,0,0,0);                 // resume: no div_clear
    for (int k = 5; k <= 7; k++) add(1,0,0,0,1, 1,k,0,0,0);
    add(1,0,0,1,1, 1,8,7,1,0);                 // lap with tick: pre-increment
    add(1,0,0,0,0, 1,8,7,0,0);
    add(1,0,1,0,0, 0,0,0,0,1);
    add(1,0,0,1,0, 0,0,0,0,0);                 // lap in IDLE ignored
    add(1,1,0,0,0, 1,0,0,0,1);
    for (int k = 1; k <= 3; k++) add(1,0,0,0,1, 1,k,0,0,0);
    add(1,1,1,1,0, 0,0,0,0,1);                 // clear beats start_stop/lap
    add(1,1,0,0,0, 1,0,0,0,1);
    for (int k = 1; k <= 12; k++) add(1,0,0,0,1, 1,k,0,0,0);
    add(0,0,0,0,1, 0,0,0,0,0);                 // reset with tick
    add(1,1,0,0,0, 1,0,0,0,1);
    add(1,0,0,0,1, 1,1,0,0,0);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst_n, tbl[i].ss, tbl[i].clr, tbl[i].lap, tbl[i].tick);
      chk($sformatf("tbl[%0d].run", i),     int'(a_run),     int'(tbl[i].e_run));
      chk($sformatf("tbl[%0d].secs", i),    int'(a_secs),    tbl[i].e_secs);
      chk($sformatf("tbl[%0d].lap", i),     int'(a_lap),     tbl[i].e_lap);
      chk($sformatf("tbl[%0d].lapv", i),    int'(a_lapv),    int'(tbl[i].e_lapv));
      chk($sformatf("tbl[%0d].wrap", i),    int'(a_wrap),    int'(tbl[i].e_wrap));
      chk($sformatf("tbl[%0d].wrapped", i), int'(a_wrapped), int'(tbl[i].e_wrapped));
      chk($sformatf("tbl[%0d].divclr", i),  int'(a_divclr),  int'(tbl[i].e_divclr));
    end

    // Wrap on the MAX_COUNT=9 instance.
    cycle(0,0,0,0,0);
    cycle(1,1,0,0,0);
    for (int k = 1; k <= 9; k++) cycle(1,0,0,0,1);
    chk("w9.secs_at_max", int'(b_secs), 9);
    chk("w9.no_wrap_yet", int'(b_wrap), 0);
    cycle(1,0,0,0,1);
    chk("w9.secs_wrapped", int'(b_secs), 0);
    chk("w9.wrap_pulse", int'(b_wrap), 1);
    chk("w9.wrapped_set", int'(b_wrapped), 1);
    chk("w9.still_run", int'(b_run), 1);
    cycle(1,0,0,0,0);
    chk("w9.wrap_one_cycle", int'(b_wrap), 0);
    chk("w9.wrapped_sticky", int'(b_wrapped), 1);
    cycle(1,0,1,0,0);
    chk("w9.clear_wrapped", int'(b_wrapped), 0);
    chk("w9.clear_secs", int'(b_secs), 0);
    chk("w9.clear_idle", int'(b_run), 0);

    // Full-range wrap on the default instance.
    cycle(1,1,0,0,0);
    for (int k = 1; k <= 9999; k++) cycle(1,0,0,0,1);
    chk("w0.secs_at_max", int'(a_secs), 9999);
    cycle(1,0,0,0,1);
    chk("w0.secs_wrapped", int'(a_secs), 0);
    chk("w0.wrap_pulse", int'(a_wrap), 1);
    chk("w0.wrapped_set", int'(a_wrapped), 1);
    cycle(1,0,0,0,0);
    chk("w0.wrap_one_cycle", int'(a_wrap), 0);
    cycle(1,0,1,0,0);

    // Random stimulus against the model.
    for (int n = 0; n < 4000; n++) begin
      cycle(($urandom_range(199) != 0),
            ($urandom_range(14) == 0),
            ($urandom_range(39) == 0),
            ($urandom_range(9) == 0),
            ($urandom_range(2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
